rr_mux_arbiter_4: RTL and testbench
===================================

Name: rr_mux_arbiter_4

Overview:
Round-robin arbiter that shares one 4:1 data mux among four requesters and drives the mux selection itself. Each winner owns the output for a burst of up to MAX_BURST accepted beats, then priority rotates. The downstream side is a valid/ready stream. It sits in front of any shared single-port consumer in the datapath.

Parameters:
WIDTH, 8, data width per requester
MAX_BURST, 4, max accepted beats per grant (legal 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester, bit i = requester i
data_in  input  4*WIDTH  packed requester data, requester i at [i*WIDTH +: WIDTH]
out_ready  input  1  downstream accepts beat this cycle
gnt  output  4  registered one-hot grant, all zero when idle
selection  output  2  registered mux select, index of current or last winner
out_valid  output  1  beat available: state==GRANT and req[selection]
out_data  output  WIDTH  data_in slice chosen by selection (combinational mux)
busy  output  1  state==GRANT

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately): state=IDLE, ptr=0, selection=0, gnt=0, beat_cnt=0, busy=0, out_valid=0. out_data then equals data_in slice 0.
- Reset mid-burst aborts the grant. A beat presented in that cycle is not counted as transferred.
- States: IDLE, GRANT.
- IDLE: if req!=0, the winner is the first set bit scanning ptr, ptr+1, ... mod 4. At the next edge: state=GRANT, selection=winner, gnt=onehot(winner), beat_cnt=0. If req==0, stay in IDLE.
- Grant latency: a request first seen in IDLE at edge N gives gnt at edge N+1.
- GRANT, transfer rule: a transfer occurs on out_valid && out_ready. Each transfer increments beat_cnt (8-bit).
- GRANT, release conditions, evaluated at each edge (either one releases):
  (a) transfer with beat_cnt==MAX_BURST-1;
  (b) req[selection]==0.
- On release: state=IDLE, gnt=0, ptr=(selection+1) mod 4, beat_cnt=0. selection keeps its value.
- One IDLE bubble cycle always follows a release. Re-arbitration happens in that cycle.
- Backpressure (out_ready=0): beat_cnt, gnt and selection hold. The requester must hold data_in stable while its req is high and the beat is unaccepted.
- A requester dropping req while out_ready=0 releases the grant without a transfer.
- Simultaneous requests: only ptr order decides. No requester waits more than 3 grants.
- The final accepted beat (condition a) and the req drop can land in the same cycle. This is a single release; ptr advances once.
- busy is identical to the registered state and never asserts in IDLE.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation with arbitrary req -> gnt=0, selection=0, busy=0, out_valid=0 immediately, without waiting for a clock.
2. Single requester: req=4'b0100, out_ready=1, data_in[2] counting 1,2,3,... -> gnt=0100 one cycle after req. Exactly 4 beats accepted with values in order, then gnt=0 for 1 cycle, then gnt=0100 again (ptr=3 wraps to 2).
3. All requesting: req=4'b1111 held, out_ready=1, MAX_BURST=4 -> grant order 0,1,2,3,0. Each grant gets 4 transfers with one idle cycle between; selection steps 0,1,2,3,0.
4. Backpressure: requester 1 granted, out_ready=0 for 3 cycles after beat 2 -> gnt=0010 and out_data held, beat_cnt stays 2. Burst completes after 2 more beats once out_ready=1.
5. Early drop: requester 1 granted, drops req after 2 beats while req[0], req[3] high -> release, ptr=2, next gnt=1000 (requester 3), then requester 0.
6. Reset mid-burst: rst_n low while requester 2 is at beat 2 -> outputs clear at once. After release with req=1111, the first grant goes to requester 0 (ptr=0).

Source files
------------

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter for four requesters sharing a single 4:1 data mux.
// A winner keeps the output for up to MAX_BURST accepted beats, then priority
// rotates to the requester after it. One idle cycle separates every grant.
module rr_mux_arbiter_4 #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   data_in,
   input  logic                 out_ready,
   output logic [3:0]           gnt,
   output logic [1:0]           selection,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 busy
);

   localparam int unsigned NREQ  = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [CNT_W-1:0]   beat_q, beat_d;

   logic               win_found;
   logic [SEL_W-1:0]   win_idx;
   logic [SEL_W-1:0]   scan_idx;
   logic               xfer;
   logic               last_xfer;
   logic               req_sel;

   // Priority scan starting at ptr, wrapping modulo four
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      scan_idx  = ptr_q;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = ptr_q + SEL_W'(k);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // State and grant bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         beat_q  <= beat_d;
      end
   end

   // Next-state: grant on any request in IDLE, release on burst end or request drop
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      gnt_d     = gnt_q;
      beat_d    = beat_q;
      req_sel   = req[sel_q];
      xfer      = (state_q == S_GRANT) && req_sel && out_ready;
      last_xfer = xfer && (beat_q == LAST_BEAT);
      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d = S_GRANT;
               sel_d   = win_idx;
               gnt_d   = NREQ'(4'b0001 << win_idx);
               beat_d  = '0;
            end
         end
         S_GRANT: begin
            if (last_xfer || !req_sel) begin
               state_d = S_IDLE;
               gnt_d   = '0;
               ptr_d   = sel_q + SEL_W'(1);
               beat_d  = '0;
            end else if (xfer) begin
               beat_d  = beat_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stream outputs: valid while the current winner still requests, data follows the mux
   always_comb begin
      busy      = (state_q == S_GRANT);
      out_valid = (state_q == S_GRANT) && req[sel_q];
      out_data  = data_in[32'(sel_q) * WIDTH +: WIDTH];
   end

   assign gnt       = gnt_q;
   assign selection = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4 (WIDTH=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_rr_mux_arbiter_4;

   localparam int unsigned WIDTH = 8;

   logic               clk;
   logic               rst_n;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] data_in;
   logic               out_ready;
   logic [3:0]         gnt;
   logic [1:0]         selection;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic               busy;

   int total;
   int bad;

   rr_mux_arbiter_4 #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .out_ready (out_ready),
      .gnt       (gnt),
      .selection (selection),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_slice(input int i, input logic [WIDTH-1:0] v);
      data_in[i*WIDTH +: WIDTH] = v;
   endtask

   // Full check of a cycle where requester g holds the grant and presents value v
   task automatic chk_grant(input string tag, input int g, input logic [WIDTH-1:0] v);
      logic [3:0] oh;
      oh = 4'(4'b0001 << g);
      chk({tag, "_gnt"},   32'(gnt), 32'(oh));
      chk({tag, "_sel"},   32'(selection), 32'(g));
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data), 32'(v));
   endtask

   task automatic chk_idle(input string tag, input int last_sel);
      chk({tag, "_gnt"},   32'(gnt), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_sel"},   32'(selection), 32'(last_sel));
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      req       = 4'b0000;
      data_in   = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) set_slice(i, 8'(8'hA0 + i));

      // reset state
      #1;
      chk("rst_gnt",   32'(gnt), 32'd0);
      chk("rst_sel",   32'(selection), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data), 32'hA0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single requester 2, four counted beats then regrant after one bubble
      req       = 4'b0100;
      out_ready = 1'b1;
      set_slice(2, 8'd1);
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         set_slice(2, 8'(k));
         #1;
         chk_grant("t2_beat", 2, 8'(k));
         @(negedge clk);
      end
      chk_idle("t2_bubble", 2);
      @(negedge clk);
      chk("t2_regrant_gnt", 32'(gnt), 32'h4);
      chk("t2_regrant_sel", 32'(selection), 32'd2);
      req = 4'b0000;
      #1;
      chk("t2_drop_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk_idle("t2_drop_idle", 2);

      // all requesting from ptr=0: order 0,1,2,3,0
      rst_n = 1'b0;
      #1;
      chk("t3_rst_sel", 32'(selection), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1111;
      for (int i = 0; i < 4; i++) set_slice(i, 8'(8'hA0 + i));
      for (int gi = 0; gi < 5; gi++) begin
         for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk_grant("t3_rr", gi % 4, 8'(8'hA0 + (gi % 4)));
         end
         if (gi < 4) begin
            @(negedge clk);
            chk_idle("t3_bubble", gi % 4);
         end
      end
      @(negedge clk);
      chk_idle("t3_end", 0);

      // backpressure on requester 1 after two beats (ptr=1 now)
      req = 4'b0010;
      set_slice(1, 8'h51);
      @(negedge clk);
      chk_grant("t4_b1", 1, 8'h51);
      @(negedge clk);
      set_slice(1, 8'h52);
      #1;
      chk_grant("t4_b2", 1, 8'h52);
      @(negedge clk);
      set_slice(1, 8'h53);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk_grant("t4_stall", 1, 8'h53);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk_grant("t4_b3", 1, 8'h53);
      @(negedge clk);
      set_slice(1, 8'h54);
      #1;
      chk_grant("t4_b4", 1, 8'h54);
      @(negedge clk);
      chk_idle("t4_release", 1);

      // early drop by requester 1 with 0 and 3 waiting (ptr=2 now)
      req = 4'b0010;
      set_slice(1, 8'h61);
      @(negedge clk);
      chk_grant("t5_b1", 1, 8'h61);
      req = 4'b1011;
      @(negedge clk);
      chk_grant("t5_b2", 1, 8'h61);
      @(negedge clk);
      req = 4'b1001;
      #1;
      chk("t5_drop_valid", 32'(out_valid), 32'd0);
      chk("t5_drop_gnt",   32'(gnt), 32'h2);
      @(negedge clk);
      chk_idle("t5_release", 1);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk_grant("t5_r3", 3, 8'hA3);
      end
      @(negedge clk);
      chk_idle("t5_bubble3", 3);
      @(negedge clk);
      chk_grant("t5_r0", 0, 8'hA0);

      // requester 0 drops, requester 2 wins from ptr=1
      req = 4'b0100;
      set_slice(2, 8'h71);
      @(negedge clk);
      chk_idle("t6_pre_idle", 0);
      @(negedge clk);
      chk_grant("t6_b1", 2, 8'h71);
      @(negedge clk);
      chk_grant("t6_b2", 2, 8'h71);
      @(negedge clk);
      chk_grant("t6_b3", 2, 8'h71);

      // asynchronous reset in the middle of the burst
      #2;
      req   = 4'b1111;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gnt",   32'(gnt), 32'd0);
      chk("t6_rst_sel",   32'(selection), 32'd0);
      chk("t6_rst_busy",  32'(busy), 32'd0);
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_data",  32'(out_data), 32'hA0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_grant("t6_after_rst", 0, 8'hA0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
